cacheline_arbiter: RTL and testbench

CACHELINE_ARBITER -- requirements
Module: cacheline_arbiter

---
 rtl/arb_pkg.sv | 22 ++
 rtl/arb_port_latch.sv | 73 +++++++
 rtl/cacheline_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_cacheline_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the two-requester cacheline arbiter: FSM states, requester
// ids and the saturating grant-counter helper.
package arb_pkg;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/arb_port_latch.sv
// Per-requester capture of op/address/wdata at grant, plus the response
// steering back to that requester while it is being served.
module arb_port_latch
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              grant,
    input  logic              served,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              active_c,
    output logic              conflict_c,
    output logic              op_read,
    output logic              op_write,
    output logic [ADDR_W-1:0] op_addr,
    output logic [LINE_W-1:0] op_wdata,
    output logic [LINE_W-1:0] rdata_c,
    output logic              resp_c
);

    logic              op_read_q,  op_read_d;
    logic              op_write_q, op_write_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [LINE_W-1:0] wdata_q,    wdata_d;

    // A simultaneous read+write resolves to the write.
    always_comb begin
        op_read_d  = op_read_q;
        op_write_d = op_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (grant) begin
            op_read_d  = req_read & ~req_write;
            op_write_d = req_write;
            addr_d     = req_addr;
            wdata_d    = req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_read_q  <= 1'b0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            op_read_q  <= op_read_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign active_c   = req_read | req_write;
    assign conflict_c = req_read & req_write;
    assign op_read    = op_read_q;
    assign op_write   = op_write_q;
    assign op_addr    = addr_q;
    assign op_wdata   = wdata_q;

    // Response is suppressed while rst is high so an abandoned transaction never completes.
    assign resp_c  = served & pmem_resp & ~rst;
    assign rdata_c = served ? pmem_rdata : '0;

endmodule

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between an icache and
// a dcache; one transaction in flight, sticky protocol-error flag.
module cacheline_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              proto_err,
    output logic [CNT_W-1:0]  i_grants,
    output logic [CNT_W-1:0]  d_grants
);

    arb_state_e       state_q, state_d;
    req_id_e          last_q,  last_d;
    logic             proto_err_q, proto_err_d;
    logic [CNT_W-1:0] i_grants_q, i_grants_d;
    logic [CNT_W-1:0] d_grants_q, d_grants_d;
    logic             i_grant_c, d_grant_c;

    logic              i_active_c, i_conflict_c, i_op_read, i_op_write;
    logic              d_active_c, d_conflict_c, d_op_read, d_op_write;
    logic [ADDR_W-1:0] i_op_addr, d_op_addr;
    logic [LINE_W-1:0] i_op_wdata, d_op_wdata;

    arb_port_latch #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_i_latch (
        .clk        (clk),
        .rst        (rst),
        .grant      (i_grant_c),
        .served     (state_q == SERVE_I),
        .req_read   (i_read),
        .req_write  (i_write),
        .req_addr   (i_addr),
        .req_wdata  (i_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp),
        .active_c   (i_active_c),
        .conflict_c (i_conflict_c),
        .op_read    (i_op_read),
        .op_write   (i_op_write),
        .op_addr    (i_op_addr),
        .op_wdata   (i_op_wdata),
        .rdata_c    (i_rdata),
        .resp_c     (i_resp)
    );

    arb_port_latch #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_d_latch (
        .clk        (clk),
        .rst        (rst),
        .grant      (d_grant_c),
        .served     (state_q == SERVE_D),
        .req_read   (d_read),
        .req_write  (d_write),
        .req_addr   (d_addr),
        .req_wdata  (d_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp),
        .active_c   (d_active_c),
        .conflict_c (d_conflict_c),
        .op_read    (d_op_read),
        .op_write   (d_op_write),
        .op_addr    (d_op_addr),
        .op_wdata   (d_op_wdata),
        .rdata_c    (d_rdata),
        .resp_c     (d_resp)
    );

    // Next-state: arbitrate in IDLE, wait for pmem_resp while serving.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        proto_err_d = proto_err_q;
        i_grants_d  = i_grants_q;
        d_grants_d  = d_grants_q;
        i_grant_c   = 1'b0;
        d_grant_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pmem_resp) begin
                    proto_err_d = 1'b1;
                end
                if (i_active_c && d_active_c) begin
                    if (last_q == REQ_I) begin
                        d_grant_c = 1'b1;
                    end else begin
                        i_grant_c = 1'b1;
                    end
                end else if (d_active_c) begin
                    d_grant_c = 1'b1;
                end else if (i_active_c) begin
                    i_grant_c = 1'b1;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (i_grant_c) begin
            state_d    = SERVE_I;
            last_d     = REQ_I;
            i_grants_d = sat_inc(i_grants_q);
            if (i_conflict_c) begin
                proto_err_d = 1'b1;
            end
        end
        if (d_grant_c) begin
            state_d    = SERVE_D;
            last_d     = REQ_D;
            d_grants_d = sat_inc(d_grants_q);
            if (d_conflict_c) begin
                proto_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= REQ_I;
            proto_err_q <= 1'b0;
            i_grants_q  <= '0;
            d_grants_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            proto_err_q <= proto_err_d;
            i_grants_q  <= i_grants_d;
            d_grants_q  <= d_grants_d;
        end
    end

    // Memory side is driven only from the served requester's latched registers.
    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        case (state_q)
            SERVE_I: begin
                pmem_read  = i_op_read;
                pmem_write = i_op_write;
                pmem_addr  = i_op_addr;
                pmem_wdata = i_op_wdata;
            end
            SERVE_D: begin
                pmem_read  = d_op_read;
                pmem_write = d_op_write;
                pmem_addr  = d_op_addr;
                pmem_wdata = d_op_wdata;
            end
            default: ;
        endcase
    end

    assign proto_err = proto_err_q;
    assign i_grants  = i_grants_q;
    assign d_grants  = d_grants_q;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter: expected memory transactions are queued
// as requests are driven and checked when the arbiter presents them to memory.
module tb_cacheline_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

    typedef struct {
        logic          is_d;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_read = 1'b0, i_write = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [LW-1:0] i_wdata = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0, d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read, pmem_write;
    logic [AW-1:0] pmem_addr;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;
    logic          proto_err;
    logic [31:0]   i_grants, d_grants;

    int   checks = 0;
    int   errors = 0;
    int   exp_i  = 0;
    int   exp_d  = 0;
    txn_t exp_q[$];

    cacheline_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_read     (i_read),
        .i_write    (i_write),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp),
        .proto_err  (proto_err),
        .i_grants   (i_grants),
        .d_grants   (d_grants)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_pmem_read"},  pmem_read,  0);
        chk({tag, "_pmem_write"}, pmem_write, 0);
        chk({tag, "_pmem_addr"},  pmem_addr,  0);
        chk({tag, "_pmem_wdata"}, pmem_wdata, 0);
        chk({tag, "_i_resp"},     i_resp,     0);
        chk({tag, "_d_resp"},     d_resp,     0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_read = 0; i_write = 0; d_read = 0; d_write = 0;
        pmem_resp = 0; pmem_rdata = '0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_proto_err", proto_err, 0);
        chk("reset_i_grants", i_grants, 0);
        chk("reset_d_grants", d_grants, 0);
        exp_i = 0;
        exp_d = 0;
        rst = 1'b0;
    endtask

    // Called at the negedge where a request is already pending; memory answers after 'delay' cycles.
    task automatic complete_txn(input int delay, input logic [LW-1:0] rd, input bit drop);
        txn_t e;
        int   n;
        n = 0;
        while (!(pmem_read || pmem_write) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_latency", 32'(n), 32'd1);
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        if (e.is_d) exp_d++; else exp_i++;
        chk("op_read",    pmem_read,  !e.wr);
        chk("op_write",   pmem_write, e.wr);
        chk("op_addr",    pmem_addr,  e.addr);
        chk("op_wdata",   pmem_wdata, e.wdata);
        chk("i_grants",   i_grants,   32'(exp_i));
        chk("d_grants",   d_grants,   32'(exp_d));
        if (drop) begin
            if (e.is_d) begin
                d_read = 0; d_write = 0; d_addr = 32'hDEAD_0000; d_wdata = ~d_wdata;
            end else begin
                i_read = 0; i_write = 0; i_addr = 32'hDEAD_0000; i_wdata = ~i_wdata;
            end
        end
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            chk("hold_read",  pmem_read,  !e.wr);
            chk("hold_write", pmem_write, e.wr);
            chk("hold_addr",  pmem_addr,  e.addr);
            chk("hold_wdata", pmem_wdata, e.wdata);
            chk("hold_no_resp", {i_resp, d_resp}, 2'b00);
        end
        pmem_rdata = rd;
        pmem_resp  = 1'b1;
        #1;
        chk("i_resp", i_resp, !e.is_d);
        chk("d_resp", d_resp, e.is_d);
        chk("rdata", e.is_d ? d_rdata : i_rdata, rd);
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        chk("idle_read",  pmem_read,  0);
        chk("idle_write", pmem_write, 0);
    endtask

    initial begin
        txn_t t;
        logic [LW-1:0] a5;
        a5 = {32{8'hA5}};

        do_reset();

        // Single icache read, memory answers in the fourth serve cycle.
        i_read = 1; i_addr = 32'h0000_0040; i_wdata = '0;
        t = '{is_d: 0, wr: 0, addr: 32'h0000_0040, wdata: '0};
        exp_q.push_back(t);
        complete_txn(3, a5, 1);
        chk("t1_i_grants_final", i_grants, 32'd1);
        chk("t1_d_grants_final", d_grants, 32'd0);

        // Simultaneous i_read and d_write from reset: dcache wins the first tie.
        do_reset();
        i_read = 1; i_addr = 32'h0000_0080; i_wdata = '0;
        d_write = 1; d_addr = 32'h2000_0100; d_wdata = {8{32'hCAFE_0001}};
        t = '{is_d: 1, wr: 1, addr: 32'h2000_0100, wdata: {8{32'hCAFE_0001}}};
        exp_q.push_back(t);
        t = '{is_d: 0, wr: 0, addr: 32'h0000_0080, wdata: '0};
        exp_q.push_back(t);
        complete_txn(1, {8{32'h1111_2222}}, 1);
        complete_txn(1, {8{32'h3333_4444}}, 1);
        chk("t2_d_grants", d_grants, 32'd1);
        chk("t2_i_grants", i_grants, 32'd1);

        // Both requesters held: grants alternate D,I,D,I,D,I.
        do_reset();
        i_read = 1; i_addr = 32'h0000_0300; i_wdata = '0;
        d_read = 1; d_addr = 32'h0000_0400; d_wdata = '0;
        for (int k = 0; k < 6; k++) begin
            t = '{is_d: (k % 2 == 0), wr: 0, addr: (k % 2 == 0) ? 32'h0000_0400 : 32'h0000_0300, wdata: '0};
            exp_q.push_back(t);
        end
        for (int k = 0; k < 6; k++) begin
            if (k == 5) d_read = 0;
            complete_txn(k % 3, {8{32'(k) + 32'h0100}}, k == 5);
        end
        chk("t3_d_grants", d_grants, 32'd3);
        chk("t3_i_grants", i_grants, 32'd3);

        // dcache write whose address changes during service.
        d_write = 1; d_addr = 32'h1000_0000; d_wdata = {8{32'h0BAD_F00D}};
        t = '{is_d: 1, wr: 1, addr: 32'h1000_0000, wdata: {8{32'h0BAD_F00D}}};
        exp_q.push_back(t);
        complete_txn(4, '0, 1);
        chk("t4_proto_err_clean", proto_err, 0);

        // Stray pmem_resp in IDLE sets the sticky error and produces no response.
        pmem_resp = 1;
        #1;
        chk("t5_i_resp", i_resp, 0);
        chk("t5_d_resp", d_resp, 0);
        @(negedge clk);
        pmem_resp = 0;
        chk("t5_proto_err_set", proto_err, 1);
        chk("t5_idle_read", pmem_read, 0);
        repeat (3) @(negedge clk);
        chk("t5_proto_err_sticky", proto_err, 1);

        // Read and write together from the icache: error flagged, write performed.
        do_reset();
        chk("t6_proto_err_cleared", proto_err, 0);
        i_read = 1; i_write = 1; i_addr = 32'h0000_0C00; i_wdata = {8{32'h5A5A_0003}};
        t = '{is_d: 0, wr: 1, addr: 32'h0000_0C00, wdata: {8{32'h5A5A_0003}}};
        exp_q.push_back(t);
        complete_txn(2, '0, 1);
        chk("t6_proto_err", proto_err, 1);

        // Reset two cycles into SERVE_I abandons the transaction.
        do_reset();
        i_read = 1; i_addr = 32'h0000_0D00; i_wdata = '0;
        @(negedge clk);
        chk("t7_serving", pmem_read, 1);
        i_read = 0;
        @(negedge clk);
        chk("t7_still_serving", pmem_read, 1);
        rst = 1;
        pmem_resp = 1;
        #1;
        chk("t7_no_i_resp", i_resp, 0);
        @(negedge clk);
        pmem_resp = 0;
        check_idle_outputs("t7_after_rst");
        chk("t7_i_grants", i_grants, 0);
        rst = 0;
        exp_i = 0;
        exp_d = 0;
        d_read = 1; d_addr = 32'h0000_0E00; d_wdata = '0;
        t = '{is_d: 1, wr: 0, addr: 32'h0000_0E00, wdata: '0};
        exp_q.push_back(t);
        complete_txn(1, {8{32'h7777_8888}}, 1);
        chk("t7_proto_err", proto_err, 0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
